// File: rtl/result_dmem_fp16.sv
// Capture memory for fp16 results: valid/ready write stream into a DEPTH x 16 array
// with auto-incrementing pointer, sticky NaN/Inf flags and a combinational read port.
//
// state   | meaning
// IDLE    | no capture armed, in_valid ignored
// CAPTURE | accepting words until count reaches len_q
// DONE    | capture complete, array holds the burst
module result_dmem_fp16 #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          in_ready,
  input  logic [AW-1:0] a,
  output logic [15:0]   q,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          nan_seen,
  output logic          inf_seen
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state, state_nx;
  logic [AW-1:0] wptr;
  logic [AW:0]   len_q;
  logic [AW:0]   len_eff;
  logic [AW:0]   count_nx;
  logic          wr_en;
  logic          last_word;
  logic          exp_max;
  logic          mant_nz;
  logic [15:0]   mem [DEPTH];

  // Out-of-range lengths collapse to a full-array capture.
  assign len_eff   = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
  assign wr_en     = in_valid && in_ready;
  assign count_nx  = count + (AW+1)'(1);
  assign last_word = wr_en && (count_nx == len_q);
  assign exp_max   = (in_data[14:10] == 5'h1F);
  assign mant_nz   = |in_data[9:0];
  assign q         = mem[a];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start)
      state_nx = CAPTURE;
    else if (state == CAPTURE && last_word)
      state_nx = DONE;
  end

  always_comb begin
    busy     = (state == CAPTURE);
    done     = (state == DONE);
    in_ready = (state == CAPTURE) && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      count    <= '0;
      len_q    <= '0;
      nan_seen <= 1'b0;
      inf_seen <= 1'b0;
    end else if (start) begin
      wptr     <= '0;
      count    <= '0;
      len_q    <= len_eff;
      nan_seen <= 1'b0;
      inf_seen <= 1'b0;
    end else if (wr_en) begin
      wptr     <= wptr + AW'(1);
      count    <= count_nx;
      nan_seen <= nan_seen | (exp_max && mant_nz);
      inf_seen <= inf_seen | (exp_max && !mant_nz);
    end
  end

  // Array deliberately has no reset so captured words survive a control reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= in_data;
  end

endmodule

// File: tb/tb_result_dmem_fp16.sv
// Directed + randomized bench for result_dmem_fp16 with a behavioural capture model.
module tb_result_dmem_fp16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [8:0]  a;
  logic [15:0] q;
  logic [9:0]  count;
  logic        busy, done, nan_seen, inf_seen;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model
  logic [15:0] ref_mem [512];
  bit          m_busy, m_done, m_nan, m_inf;
  int          m_cnt, m_len, m_wp;

  result_dmem_fp16 #(.DEPTH(512), .AW(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .a(a), .q(q), .count(count), .busy(busy), .done(done),
    .nan_seen(nan_seen), .inf_seen(inf_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_nan = 0; m_inf = 0;
    m_cnt = 0; m_wp = 0; m_len = 0;
  endtask

  task automatic check_ctrl(input string tag);
    chk({tag, "_busy"},  busy,     m_busy);
    chk({tag, "_done"},  done,     m_done);
    chk({tag, "_rdy"},   in_ready, m_busy && !start);
    chk({tag, "_count"}, count,    m_cnt);
    chk({tag, "_nan"},   nan_seen, m_nan);
    chk({tag, "_inf"},   inf_seen, m_inf);
  endtask

  // Advance one clock: update the model from the inputs as driven, then compare.
  task automatic cycle(input string tag);
    if (start) begin
      m_cnt = 0; m_wp = 0; m_nan = 0; m_inf = 0;
      m_len = (len == 0 || len > 512) ? 512 : int'(len);
      m_busy = 1; m_done = 0;
    end else if (m_busy && in_valid) begin
      ref_mem[m_wp] = in_data;
      m_wp = (m_wp + 1) % 512;
      m_cnt++;
      if (in_data[14:10] == 5'h1F) begin
        if (in_data[9:0] != 0) m_nan = 1;
        else                   m_inf = 1;
      end
      if (m_cnt == m_len) begin m_busy = 0; m_done = 1; end
    end
    @(posedge clk); #1;
    check_ctrl(tag);
  endtask

  task automatic do_start(input logic [9:0] l);
    start = 1; len = l; in_valid = 0;
    cycle("start");
    start = 0;
  endtask

  task automatic readback(input string tag, input int lo, input int hi);
    in_valid = 0;
    for (int i = lo; i <= hi; i++) begin
      a = 9'(i); #1;
      chk(tag, q, ref_mem[i]);
    end
  endtask

  logic [15:0] vec1 [20] = '{16'h4601, 16'h38B4, 16'h3C9D, 16'h3B9C, 16'h8000,
                             16'h3B9C, 16'hB4CB, 16'h38B4, 16'hB0D2, 16'h8000,
                             16'h30D2, 16'hB8B4, 16'h34CB, 16'hBB9C, 16'h8000,
                             16'hBB9C, 16'hBC9D, 16'hB8B4, 16'hC601, 16'h8000};

  initial begin
    logic [15:0] keep0;
    int guard;
    rst_n = 0; start = 0; len = 0; in_valid = 0; in_data = 0; a = 0;
    model_reset();
    #3;
    check_ctrl("reset");
    @(negedge clk); rst_n = 1;
    cycle("idle");

    // fixed 20-word burst, in_valid held high
    do_start(10'd20);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_data = vec1[i];
      cycle("burst");
      chk("burst_done_edge", done, (i == 19));
    end
    chk("burst_count20", count, 20);
    in_valid = 0;
    for (int i = 0; i < 20; i++) begin
      a = 9'(i); #1;
      chk("burst_rd", q, vec1[i]);
    end
    a = 9'd4; #1;
    chk("neg_zero", q, 16'h8000);

    // random valid gaps, len=7
    do_start(10'd7);
    guard = 0;
    while (m_busy && guard < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom) & 16'h7BFF;
      cycle("gaps");
      guard++;
    end
    chk("gaps_timeout", guard < 200, 1);
    chk("gaps_rdy_low", in_ready, 0);
    in_valid = 1; in_data = 16'h1234;
    for (int i = 0; i < 3; i++) cycle("gaps_ignored");
    chk("gaps_count7", count, 7);
    readback("gaps_rd", 0, 6);

    // inf then nan injection, cleared by next start
    do_start(10'd10);
    in_valid = 1; in_data = 16'h3C00; cycle("flag_norm");
    in_data = 16'h7C00; cycle("flag_inf");
    chk("inf_set", inf_seen, 1);
    chk("nan_clr", nan_seen, 0);
    in_data = 16'h7E01; cycle("flag_nan");
    chk("nan_set", nan_seen, 1);
    in_valid = 0;
    do_start(10'd10);
    chk("inf_cleared", inf_seen, 0);
    chk("nan_cleared", nan_seen, 0);

    // len=0 -> full array
    do_start(10'd0);
    for (int i = 0; i < 512; i++) begin
      in_valid = 1; in_data = 16'($urandom);
      cycle("full");
    end
    chk("full_done", done, 1);
    chk("full_count", count, 512);
    readback("full_rd", 0, 511);
    a = 9'd0; #1; keep0 = q;
    in_valid = 1; in_data = ~keep0;
    for (int i = 0; i < 3; i++) cycle("full_ignored");
    a = 9'd0; #1;
    chk("full_mem0_kept", q, ref_mem[0]);
    chk("full_count_hold", count, 512);

    // restart after 5 words; word alongside start is dropped
    do_start(10'd10);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 16'($urandom) & 16'h7BFF;
      cycle("rs_pre");
    end
    start = 1; len = 10'd10; in_valid = 1; in_data = 16'hDEAD;
    cycle("rs_start");
    start = 0;
    chk("rs_count0", count, 0);
    in_data = 16'h2468; cycle("rs_next");
    a = 9'd0; #1;
    chk("rs_a0", q, 16'h2468);

    // async reset mid-capture
    do_start(10'd10);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 16'($urandom) & 16'h7BFF;
      cycle("rst_pre");
    end
    in_valid = 1; in_data = 16'h7C00;
    #2 rst_n = 0;
    model_reset();
    #1 check_ctrl("rst_async");
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) cycle("rst_after");
    readback("rst_kept", 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_dmem_fp16.md
# result_dmem_fp16

Writable capture memory for fp16 results. Sits at the FPU output and stores a burst of results into a 512 x 16 array. It accepts results over a valid/ready stream with an auto-incrementing write pointer, and flags NaN/Inf results. It exposes the same combinational `a`/`q` read port as the constant data memories, so a bench or a downstream stage can read the captured vector back the same way it reads stimulus.

## Interface
- `DEPTH`, 512, number of 16-bit words; power of two
- `AW`, 9, address width = log2(DEPTH)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse: arm a new capture of `len` words
- `len`  in  AW+1  capture length, sampled when `start`=1; 0 or >DEPTH means DEPTH
- `in_valid`  in  1  producer has a result on `in_data`
- `in_data`  in  16  fp16 result word
- `in_ready`  out  1  block accepts `in_data` this cycle
- `a`  in  AW  read address
- `q`  out  16  `mem[a]`, combinational
- `count`  out  AW+1  words written since last `start`
- `busy`  out  1  state == CAPTURE
- `done`  out  1  state == DONE (level)
- `nan_seen`  out  1  sticky: a captured word had exp=5'h1F and mant!=0
- `inf_seen`  out  1  sticky: a captured word had exp=5'h1F and mant==0

## Operation
- States: IDLE, CAPTURE, DONE.
  - IDLE --start--> CAPTURE
  - CAPTURE --last accepted word--> DONE
  - CAPTURE --start--> CAPTURE (restart)
  - DONE --start--> CAPTURE
- On `start`:
  - `wptr` and `count` go to 0.
  - `nan_seen` and `inf_seen` clear.
  - `len_q` loads `len`; a value of 0 or >DEPTH becomes DEPTH.
- Write handshake: `in_valid && in_ready` at a rising edge.
  - Writes `mem[wptr] <= in_data`.
  - `wptr <= wptr+1` (wraps modulo DEPTH; only reachable with `len_q`=DEPTH on the final word).
  - `count <= count+1`.
  - ORs the classification of `in_data` into the sticky flags.
- `in_ready = busy && !start`. A word presented in the same cycle as `start` is not accepted and is not written.
- When the accepted word makes `count == len_q`, the state goes to DONE at that edge.
- `in_valid` in IDLE or DONE is ignored; nothing is written and no counter changes.
- Read port: `q = mem[a]`, purely combinational and available in every state, including mid-capture.
  - Read-during-write to the same address returns the old word until the write edge, then the new word.
- Sign of zero is preserved bit-exact: 16'h8000 and 16'h0000 are stored distinctly. Neither sets a flag.
- The array is not reset; its contents are undefined until written. All control state is reset.

## Timing
- Reset values (async, while `rst_n`=0): state IDLE, `in_ready` 0, `busy` 0, `done` 0, `count` 0, `wptr` 0, `nan_seen` 0, `inf_seen` 0. `q` is undefined-data but still tracks `a`.
- `rst_n` deasserted mid-capture: the capture is abandoned, and words already written stay in the array.
- `start` at edge N:
  - `busy`=1 and `in_ready`=1 in cycle N+1 (if `start` is low then).
  - `done` drops at edge N.
- Throughput is one word per cycle with no bubbles. Latency from the write edge to visibility on `q` is 0 cycles after the edge.
- `count`, `wptr` and the flags update at the same edge as the write.
- Final accepted word at edge M: `done`=1, `busy`=0 and `in_ready`=0 from M onward.
- Back-to-back `start` pulses: each one restarts; the last one wins.

## Test plan
- Reset, then `start` with `len`=20 and feed the 20 words 4601,38B4,3C9D,3B9C,8000,3B9C,B4CB,38B4,B0D2,8000,30D2,B8B4,34CB,BB9C,8000,BB9C,BC9D,B8B4,C601,8000 with `in_valid` held high:
  - `done` rises on edge 20 after `start`, with `count`=20.
  - Reading `a`=0..19 returns the words in order; `a`=4 returns 8000, not 0000.
- Random `in_valid` gaps (~50% duty) with `len`=7: exactly 7 words are stored, `count` only advances on handshakes, and `in_ready` falls immediately after the 7th.
- Inject 7C00 then 7E01 while capturing: `inf_seen`=1 after the first edge, `nan_seen`=1 after the second; both clear on the next `start`.
- `len`=0: 512 words accepted, last at `a`=511, `count`=512, `done`=1; further `in_valid` writes nothing (`mem[0]` unchanged).
- `start` pulsed again after 5 words with `in_valid`=1 in the same cycle: that word is dropped, `count`=0, and the next word lands at `a`=0.
- Assert `rst_n`=0 mid-capture: all outputs hit their reset values immediately (asynchronously) and `in_ready`=0 until the next `start`.
